// File: rtl/dpc_pkg.sv
// Shared types and default widths for the manual defect-pixel correction block.
// The beat struct carries a pixel together with its frame/line position flags.
package dpc_pkg;

  localparam int DPC_WIDTH_BITS    = 10;
  localparam int DPC_HEIGHT_BITS   = 10;
  localparam int DPC_BAD_POINT_BIT = 7;
  localparam int DPC_DATA_WIDTH    = 14;

  typedef struct packed {
    logic [DPC_DATA_WIDTH-1:0] data;
    logic                      sof;
    logic                      eol;
    logic                      bad;
    logic                      first;
  } dpc_beat_t;

endpackage

// File: rtl/dpc_avg2.sv
// Neighbour select / two-point average used to replace a flagged pixel.
// Line-edge pixels borrow their single in-line neighbour instead of averaging.
module dpc_avg2 #(
  parameter int W = 14
) (
  input  logic [W-1:0] cur_data,
  input  logic [W-1:0] prev_data,
  input  logic [W-1:0] next_data,
  input  logic         bad,
  input  logic         first,
  input  logic         eol,
  output logic [W-1:0] out_data
);

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, prev_data} + {1'b0, next_data};
    out_data = cur_data;
    if (bad) begin
      if (first && eol) begin
        out_data = cur_data;
      end else if (first) begin
        out_data = next_data;
      end else if (eol) begin
        out_data = prev_data;
      end else begin
        out_data = W'(sum >> 1);
      end
    end
  end

endmodule

// File: rtl/manual_dpc_correct.sv
// Manual defect-pixel correction against an external sequential bad-point LUT.
// Optional MANUAL_DPC_STATS_EN adds corr_count (previous frame's hit count).
module manual_dpc_correct
  import dpc_pkg::*;
#(
  parameter int WIDTH_BITS    = DPC_WIDTH_BITS,
  parameter int HEIGHT_BITS   = DPC_HEIGHT_BITS,
  parameter int BAD_POINT_BIT = DPC_BAD_POINT_BIT,
  parameter int DATA_WIDTH    = DPC_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_sof,
  input  logic                     s_eol,
  input  logic [WIDTH_BITS-1:0]    width_bad,
  input  logic [HEIGHT_BITS-1:0]   height_bad,
  input  logic [BAD_POINT_BIT-1:0] bad_point_num,
  output logic                     shift,
  output logic                     m_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     m_bad
`ifdef MANUAL_DPC_STATS_EN
  ,
  output logic [BAD_POINT_BIT:0]   corr_count
`endif
);

  logic [WIDTH_BITS-1:0]  x_q, x_d, cur_x;
  logic [HEIGHT_BITS-1:0] y_q, y_d, cur_y;
  logic [BAD_POINT_BIT:0] match_cnt_q, match_cnt_d, cnt_base;
  logic                   armed_q, armed_d;
  logic                   cur_valid_q, cur_valid_d;
  dpc_beat_t              cur_q, cur_d;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d, fix_data;
  logic                   accept, hit, emit;
  logic                   m_valid_q, m_valid_d, m_sof_q, m_sof_d;
  logic                   m_eol_q, m_eol_d, m_bad_q, m_bad_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;

  dpc_avg2 #(.W(DATA_WIDTH)) u_avg2 (
    .cur_data  (DATA_WIDTH'(cur_q.data)),
    .prev_data (prev_q),
    .next_data (s_data),
    .bad       (cur_q.bad),
    .first     (cur_q.first),
    .eol       (cur_q.eol),
    .out_data  (fix_data)
  );

  always_comb begin
    cur_x    = s_sof ? '0 : x_q;
    cur_y    = s_sof ? '0 : y_q;
    cnt_base = s_sof ? '0 : match_cnt_q;
    // Until the first s_sof after reset, beats are ignored entirely.
    accept   = s_valid & (armed_q | s_sof);
    hit      = accept & (cur_x == width_bad) & (cur_y == height_bad) &
               (cnt_base < {1'b0, bad_point_num});
    emit     = cur_valid_q & (accept | cur_q.eol);

    x_d         = x_q;
    y_d         = y_q;
    match_cnt_d = match_cnt_q;
    armed_d     = armed_q;
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    prev_d      = prev_q;

    if (accept) begin
      armed_d     = 1'b1;
      x_d         = s_eol ? '0 : cur_x + WIDTH_BITS'(1);
      y_d         = s_eol ? cur_y + HEIGHT_BITS'(1) : cur_y;
      match_cnt_d = cnt_base + {{BAD_POINT_BIT{1'b0}}, hit};
      cur_d.data  = DPC_DATA_WIDTH'(s_data);
      cur_d.sof   = s_sof;
      cur_d.eol   = s_eol;
      cur_d.bad   = hit;
      cur_d.first = (cur_x == '0);
      cur_valid_d = 1'b1;
      // prev always holds the raw pixel, so corrections never chain.
      if (cur_valid_q) prev_d = DATA_WIDTH'(cur_q.data);
    end else if (emit) begin
      cur_valid_d = 1'b0;
    end

    m_valid_d = emit;
    m_data_d  = emit ? fix_data  : m_data_q;
    m_sof_d   = emit ? cur_q.sof : m_sof_q;
    m_eol_d   = emit ? cur_q.eol : m_eol_q;
    m_bad_d   = emit ? cur_q.bad : m_bad_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      match_cnt_q <= '0;
      armed_q     <= 1'b0;
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      prev_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      m_bad_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      match_cnt_q <= match_cnt_d;
      armed_q     <= armed_d;
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      prev_q      <= prev_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_sof_q     <= m_sof_d;
      m_eol_q     <= m_eol_d;
      m_bad_q     <= m_bad_d;
    end
  end

  assign shift   = hit;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;
  assign m_bad   = m_bad_q;

`ifdef MANUAL_DPC_STATS_EN
  logic [BAD_POINT_BIT:0] corr_count_q, corr_count_d;

  always_comb begin
    corr_count_d = (accept & s_sof) ? match_cnt_q : corr_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) corr_count_q <= '0;
    else        corr_count_q <= corr_count_d;
  end

  assign corr_count = corr_count_q;
`endif

endmodule

// File: tb/tb_manual_dpc_correct.sv
// Self-checking bench for manual_dpc_correct: LUT model driven by shift,
// expected pixels queued at drive time and compared as they emerge.
module tb_manual_dpc_correct;

  localparam int WB = 10;
  localparam int HB = 10;
  localparam int BP = 7;
  localparam int DW = 14;
  localparam int EW = DW + 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid, s_sof, s_eol;
  logic [DW-1:0] s_data;
  logic [WB-1:0] width_bad;
  logic [HB-1:0] height_bad;
  logic [BP-1:0] bad_point_num;
  logic          shift, m_valid, m_sof, m_eol, m_bad;
  logic [DW-1:0] m_data;
`ifdef MANUAL_DPC_STATS_EN
  logic [BP:0]   corr_count;
`endif

  manual_dpc_correct #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .BAD_POINT_BIT(BP), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .width_bad(width_bad), .height_bad(height_bad), .bad_point_num(bad_point_num),
    .shift(shift), .m_valid(m_valid), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_bad(m_bad)
`ifdef MANUAL_DPC_STATS_EN
    , .corr_count(corr_count)
`endif
  );

  // external LUT model: next entry presented one cycle after shift
  int lut_x[8];
  int lut_y[8];
  int lut_n;
  int lut_idx;
  int lut_base;
  assign width_bad     = WB'(lut_x[(lut_idx - lut_base) & 7]);
  assign height_bad    = HB'(lut_y[(lut_idx - lut_base) & 7]);
  assign bad_point_num = BP'(lut_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lut_idx <= 0;
    else if (shift) lut_idx <= lut_idx + 1;
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic          exp_shift;
  int            n_cmp = 0;
  int            n_err = 0;
  int            pix[64];
  int            k_hits;
  int            prev_hits;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("shift", 32'(shift), s_valid ? 32'(exp_shift) : 32'd0);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_m_valid", 32'(m_valid), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_eq("m_data", 32'(m_data), 32'(exp_e[DW-1:0]));
          check_eq("m_bad_sof_eol", 32'({m_bad, m_sof, m_eol}), 32'(exp_e[DW+2:DW]));
        end
      end
    end
  end

  // driver tasks
  task automatic idle();
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; exp_shift = 1'b0;
  endtask

  task automatic drive_frame(input int w, input int h, input bit gaps, input int nbeats);
    int k;
    int x;
    int y;
    int val;
    bit hitm;
    k = 0;
    lut_base = lut_idx;
    for (int b = 0; b < nbeats; b++) begin
      x = b % w;
      y = b / w;
      if (gaps) repeat ($urandom_range(0, 1)) idle();
      hitm = (k < lut_n) && (x == lut_x[k]) && (y == lut_y[k]);
      val = pix[b];
      if (hitm) begin
        if (x == 0 && x == w - 1) val = pix[b];
        else if (x == 0)          val = pix[b + 1];
        else if (x == w - 1)      val = pix[b - 1];
        else                      val = (pix[b - 1] + pix[b + 1]) >> 1;
      end
      exp_q.push_back({hitm, b == 0, x == w - 1, DW'(val)});
      @(posedge clk); #1;
`ifdef MANUAL_DPC_STATS_EN
      if (b == 1) check_eq("corr_count", 32'(corr_count), 32'(prev_hits));
`endif
      s_valid = 1'b1; s_data = DW'(pix[b]); s_sof = (b == 0);
      s_eol = (x == w - 1); exp_shift = hitm;
      if (hitm) k++;
    end
    idle();
    k_hits = k;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    idle();
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++) pix[i] = $urandom_range(0, (1 << DW) - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; exp_shift = 1'b0;
    lut_x = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_n = 0; lut_base = 0; prev_hits = 0; k_hits = 0;

    repeat (3) @(posedge clk); #1;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_flags", 32'({m_sof, m_eol, m_bad}), 32'd0);
    check_eq("rst_shift", 32'(shift), 32'd0);
`ifdef MANUAL_DPC_STATS_EN
    check_eq("rst_corr_count", 32'(corr_count), 32'd0);
`endif
    rst_n = 1'b1;
    idle();

    // single interior bad point plus both line edges on row 1
    pix[0:7] = '{10, 20, 99, 40, 50, 60, 70, 80};
    lut_x = '{2, 0, 3, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{0, 1, 1, 1023, 1023, 1023, 1023, 1023};
    lut_n = 3;
    drive_frame(4, 2, 1'b1, 8);
    drain();
    prev_hits = k_hits;

    // adjacent bad points, back-to-back beats
    pix[0:3] = '{10, 90, 90, 40};
    lut_x = '{1, 2, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{0, 0, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_n = 2;
    drive_frame(4, 1, 1'b0, 4);
    drain();
    prev_hits = k_hits;

    // zero valid entries: pass-through even though LUT matches (0,0)
    rand_pix(8);
    lut_x = '{0, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{0, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_n = 0;
    drive_frame(4, 2, 1'b1, 8);
    drain();
    prev_hits = k_hits;

    // random frames, LUT entry count sometimes below list length
    for (int f = 0; f < 3; f++) begin
      rand_pix(24);
      p = -1;
      for (int i = 0; i < 8; i++) begin
        p = p + 1 + $urandom_range(0, 4);
        lut_x[i] = (p < 24) ? p % 8 : 1023;
        lut_y[i] = (p < 24) ? p / 8 : 1023;
      end
      lut_n = $urandom_range(0, 5);
      drive_frame(8, 3, f[0], 24);
      drain();
      prev_hits = k_hits;
    end

    // mid-line reset
    rand_pix(24);
    lut_x = '{1, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{0, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_n = 1;
    drive_frame(8, 3, 1'b0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_m_data", 32'(m_data), 32'd0);
    check_eq("midrst_flags", 32'({m_sof, m_eol, m_bad}), 32'd0);
    check_eq("midrst_shift", 32'(shift), 32'd0);
`ifdef MANUAL_DPC_STATS_EN
    check_eq("midrst_corr_count", 32'(corr_count), 32'd0);
`endif
    exp_q.delete();
    lut_base = 0;
    prev_hits = 0;
    lut_x = '{0, 1, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_y = '{0, 1, 1023, 1023, 1023, 1023, 1023, 1023};
    lut_n = 2;
    @(negedge clk);
    rst_n = 1'b1;

    // beats without a preceding s_sof are dropped: no output, no shift
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = DW'(100 + i); s_sof = 1'b0;
      s_eol = (i == 2); exp_shift = 1'b0;
    end
    repeat (4) idle();

    rand_pix(8);
    drive_frame(4, 2, 1'b1, 8);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
